// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial add sequencer: state encoding.
package serial_adder_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/halfadder.sv
// One-bit half adder; two of these form the serial full-adder bit slice.
module halfadder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  // Pure combinational sum/carry of two bits.
  always_comb begin
    sum   = a ^ b;
    carry = a & b;
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer: {cout,sum} = a + b + cin, one bit per clock, LSB first.
//
// Handshake: start is a request that is only accepted on a clock edge while
// the engine is idle (busy=0); a, b and cin are captured on that same edge.
// Requests while busy=1 are dropped, never queued. done is a one-cycle pulse
// marking sum/cout valid; sum/cout then hold until the next accepted start.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Bit counter is $clog2(WIDTH) wide, but never narrower than one bit.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_r;
  logic             carry;
  logic             cout_r;
  logic [CW-1:0]    count;
  logic             last;

  logic ha1_sum;
  logic ha1_carry;
  logic bit_sum;
  logic ha2_carry;
  logic carry_next;

  // Full adder for the current bit: half adder on the operand bits, then
  // a second half adder folding in the running carry.
  halfadder u_ha1 (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .sum   (ha1_sum),
    .carry (ha1_carry)
  );

  halfadder u_ha2 (
    .a     (ha1_sum),
    .b     (carry),
    .sum   (bit_sum),
    .carry (ha2_carry)
  );

  assign carry_next = ha1_carry | ha2_carry;
  assign last       = (count == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: RUN lasts exactly WIDTH edges, DONE exactly one.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:  busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: operand capture, LSB-first shifting, carry flop, bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= cin;
            sum_r  <= '0;
            cout_r <= 1'b0;
            count  <= '0;
          end
        end
        RUN: begin
          // New bit enters at the MSB; after WIDTH shifts the LSB-first
          // result sits in natural bit order.
          sum_r <= (sum_r >> 1) | (WIDTH'(bit_sum) << (WIDTH - 1));
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= carry_next;
          count <= count + 1'b1;
          if (last) begin
            cout_r <= carry_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 main instance plus a WIDTH=1 instance.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       cin8;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       cin1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       cout1;

  int n_cmp;
  int n_err;

  logic [8:0] exp_q[$];

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL reset_busy8 got=%b exp=0", busy8); end
    n_cmp++; if (done8 !== 1'b0) begin n_err++; $display("FAIL reset_done8 got=%b exp=0", done8); end
    n_cmp++; if (sum8 !== 8'h00) begin n_err++; $display("FAIL reset_sum8 got=%h exp=00", sum8); end
    n_cmp++; if (cout8 !== 1'b0) begin n_err++; $display("FAIL reset_cout8 got=%b exp=0", cout8); end
    n_cmp++; if ({busy1, done1, sum1, cout1} !== 4'b0000) begin n_err++; $display("FAIL reset_w1 got=%b exp=0000", {busy1, done1, sum1, cout1}); end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Driver + checker for one WIDTH=8 operation; pulse start, walk every cycle
  // through DONE and back to IDLE checking busy/done timing and the result.
  task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                         input logic [8:0] exp, input string name);
    logic [8:0] e;
    start8 = 1'b1; a8 = ta; b8 = tb_v; cin8 = tc;
    exp_q.push_back(exp);
    tick();  // edge E0
    start8 = 1'b0;
    a8 = 8'($urandom_range(0, 255));
    b8 = 8'($urandom_range(0, 255));
    cin8 = 1'($urandom_range(0, 1));
    n_cmp++; if (busy8 !== 1'b1 || done8 !== 1'b0) begin n_err++; $display("FAIL %s_accept busy/done got=%b%b exp=10", name, busy8, done8); end
    n_cmp++; if ({cout8, sum8} !== 9'h000) begin n_err++; $display("FAIL %s_cleared got=%h exp=000", name, {cout8, sum8}); end
    for (int k = 1; k <= 8; k++) begin
      tick();  // edge E0+k
      if (k < 8) begin
        n_cmp++; if (busy8 !== 1'b1 || done8 !== 1'b0) begin n_err++; $display("FAIL %s_run%0d busy/done got=%b%b exp=10", name, k, busy8, done8); end
      end else begin
        e = exp_q.pop_front();
        n_cmp++; if (busy8 !== 1'b1 || done8 !== 1'b1) begin n_err++; $display("FAIL %s_done busy/done got=%b%b exp=11", name, busy8, done8); end
        n_cmp++; if ({cout8, sum8} !== e) begin n_err++; $display("FAIL %s_result got=%h exp=%h", name, {cout8, sum8}, e); end
      end
    end
    tick();  // edge E0+9: back in IDLE, result held
    n_cmp++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin n_err++; $display("FAIL %s_idle busy/done got=%b%b exp=00", name, busy8, done8); end
    n_cmp++; if ({cout8, sum8} !== exp) begin n_err++; $display("FAIL %s_held got=%h exp=%h", name, {cout8, sum8}, exp); end
  endtask

  task automatic test_basic();
    run_op8(8'h3C, 8'h5A, 1'b0, 9'h096, "basic");
  endtask

  task automatic test_carry();
    run_op8(8'hFF, 8'h01, 1'b0, 9'h100, "carry_ff01");
    run_op8(8'hFF, 8'hFF, 1'b1, 9'h1FF, "carry_ffff1");
  endtask

  task automatic test_ignore_start();
    int pulses;
    pulses = 0;
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    tick();  // E0
    start8 = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      if (k == 2 || k == 8) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      tick();  // E0+k
      if (done8 === 1'b1) pulses++;
      if (k == 8) begin
        n_cmp++; if ({cout8, sum8} !== 9'h046) begin n_err++; $display("FAIL ignore_result got=%h exp=046", {cout8, sum8}); end
      end
      if (k == 10) begin
        n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL ignore_no_restart busy got=%b exp=0", busy8); end
      end
    end
    start8 = 1'b0;
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL ignore_pulses got=%0d exp=1", pulses); end
    n_cmp++; if ({cout8, sum8} !== 9'h046) begin n_err++; $display("FAIL ignore_held got=%h exp=046", {cout8, sum8}); end
  endtask

  task automatic test_async_reset();
    start8 = 1'b1; a8 = 8'h55; b8 = 8'h0F; cin8 = 1'b0;
    tick();  // E0
    start8 = 1'b0;
    repeat (4) tick();  // E0+4, four low bits of 0x64 processed
    n_cmp++; if (sum8 !== 8'h40 || busy8 !== 1'b1) begin n_err++; $display("FAIL arst_partial sum/busy got=%h/%b exp=40/1", sum8, busy8); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if ({busy8, done8, cout8, sum8} !== 11'h000) begin n_err++; $display("FAIL arst_clear got=%h exp=000", {busy8, done8, cout8, sum8}); end
    tick();
    n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL arst_hold busy got=%b exp=0", busy8); end
    rst = 1'b0;
    tick();
    run_op8(8'h01, 8'h01, 1'b0, 9'h002, "after_rst");
  endtask

  task automatic test_back_to_back();
    int accepts;
    logic busy_prev;
    accepts = 0;
    busy_prev = busy8;
    start8 = 1'b1; a8 = 8'h21; b8 = 8'h43; cin8 = 1'b0;
    for (int k = 0; k <= 19; k++) begin
      tick();  // E0+k
      if (busy8 === 1'b1 && busy_prev === 1'b0) accepts++;
      busy_prev = busy8;
      if (k == 0) begin
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1;
      end
      if (k == 8) begin
        n_cmp++; if (done8 !== 1'b1 || {cout8, sum8} !== 9'h064) begin n_err++; $display("FAIL b2b_first got=%b/%h exp=1/064", done8, {cout8, sum8}); end
      end
      if (k == 9) begin
        n_cmp++; if (busy8 !== 1'b0 || {cout8, sum8} !== 9'h064) begin n_err++; $display("FAIL b2b_gap got=%b/%h exp=0/064", busy8, {cout8, sum8}); end
      end
      if (k == 10) begin
        n_cmp++; if (busy8 !== 1'b1 || {cout8, sum8} !== 9'h000) begin n_err++; $display("FAIL b2b_reaccept got=%b/%h exp=1/000", busy8, {cout8, sum8}); end
      end
      if (k == 18) begin
        n_cmp++; if (done8 !== 1'b1 || {cout8, sum8} !== 9'h101) begin n_err++; $display("FAIL b2b_second got=%b/%h exp=1/101", done8, {cout8, sum8}); end
      end
    end
    start8 = 1'b0;
    n_cmp++; if (accepts != 2) begin n_err++; $display("FAIL b2b_accepts got=%0d exp=2", accepts); end
    tick();
    tick();
  endtask

  task automatic test_width1();
    logic [1:0] exp_tab [8];
    logic [2:0] idx;
    // indexed by {cin,a,b}
    exp_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      start1 = 1'b1; cin1 = idx[2]; a1 = idx[1]; b1 = idx[0];
      tick();  // E0
      start1 = 1'b0;
      n_cmp++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin n_err++; $display("FAIL w1_accept%0d busy/done got=%b%b exp=10", i, busy1, done1); end
      tick();  // E0+1
      n_cmp++; if (done1 !== 1'b1 || {cout1, sum1} !== exp_tab[i]) begin n_err++; $display("FAIL w1_result%0d got=%b/%b exp=1/%b", i, done1, {cout1, sum1}, exp_tab[i]); end
      tick();  // back to IDLE
      n_cmp++; if (busy1 !== 1'b0 || {cout1, sum1} !== exp_tab[i]) begin n_err++; $display("FAIL w1_held%0d got=%b/%b exp=0/%b", i, busy1, {cout1, sum1}, exp_tab[i]); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_width1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
